// File: rtl/fifo_stream_reader.sv
// Read-side adapter: pops a FIFO and presents its words as a valid/ready stream.
// A small credit-limited prefetch buffer hides the FIFO read latency.
module fifo_stream_reader #(
    parameter int WIDTH_DATA = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fifo_rd_en,
    input  logic [WIDTH_DATA-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH_DATA-1:0] m_data,
    output logic [1:0]            buf_cnt
);

    localparam int _DEPTH = RD_LATENCY + 2;
    localparam int PW = (_DEPTH > 2) ? 2 : 1;
    localparam logic [1:0] DEPTH_C = 2'(_DEPTH);
    localparam logic [2:0] DEPTH_W = 3'(_DEPTH);
    localparam logic [PW-1:0] LAST_C = PW'(_DEPTH - 1);

    if (RD_LATENCY != 0 && RD_LATENCY != 1) begin : g_bad_lat
        $error("fifo_stream_reader: RD_LATENCY must be 0 or 1");
    end

    logic [WIDTH_DATA-1:0] mem_q [_DEPTH];
    logic [PW-1:0]         wr_ptr_q;
    logic [PW-1:0]         wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         rd_ptr_d;
    logic [1:0]            cnt_q;
    logic [1:0]            cnt_d;
    logic                  inflight;
    logic                  arrival;
    logic                  xfer;
    logic [2:0]            occ;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    // Latency 1: a pop issued this cycle returns data next cycle.
    if (RD_LATENCY == 1) begin : g_lat1
        logic inflight_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                inflight_q <= 1'b0;
            end else begin
                inflight_q <= fifo_rd_en;
            end
        end

        assign inflight = inflight_q;
        assign arrival  = inflight_q && !flush;
    end else begin : g_lat0
        assign inflight = 1'b0;
        assign arrival  = fifo_rd_en;
    end

    // Credits count words already buffered plus words still on the way.
    assign occ        = {1'b0, cnt_q} + {2'b00, inflight};
    assign fifo_rd_en = !rst && !flush && !fifo_empty && (occ < DEPTH_W);

    assign m_valid = (cnt_q != 2'd0);
    assign m_data  = mem_q[rd_ptr_q];
    assign buf_cnt = cnt_q;
    assign xfer    = m_valid && m_ready && !flush;

    always_comb begin
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (arrival) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (xfer) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + {1'b0, arrival} - {1'b0, xfer};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < _DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (arrival) begin
                mem_q[wr_ptr_q] <= fifo_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (cnt_q <= DEPTH_C);
            assert (!(arrival && !xfer && cnt_q == DEPTH_C));
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench: latency-0 and latency-1 readers driven side by side, each against
// its own queue-based FIFO model and expected-buffer model.
module tb_fifo_stream_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       flush;
    logic       m_ready;
    logic       rd_en   [2];
    logic       empty   [2];
    logic [7:0] rd_data [2];
    logic       mv      [2];
    logic [7:0] md      [2];
    logic [1:0] bc      [2];

    fifo_stream_reader #(.WIDTH_DATA(8), .RD_LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst),
        .fifo_rd_en(rd_en[0]), .fifo_rd_data(rd_data[0]),
        .fifo_empty(empty[0]), .flush(flush),
        .m_valid(mv[0]), .m_ready(m_ready),
        .m_data(md[0]), .buf_cnt(bc[0])
    );

    fifo_stream_reader #(.WIDTH_DATA(8), .RD_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst),
        .fifo_rd_en(rd_en[1]), .fifo_rd_data(rd_data[1]),
        .fifo_empty(empty[1]), .flush(flush),
        .m_valid(mv[1]), .m_ready(m_ready),
        .m_data(md[1]), .buf_cnt(bc[1])
    );

    typedef logic [7:0] q8_t [$];

    q8_t        src  [2];
    q8_t        bufm [2];
    q8_t        pend [2];
    bit         hold    [2];
    bit         zero_ok [2];
    logic [7:0] nxt1;
    int         aa_seen;
    bit         ph5;
    int         total;
    int         bad;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic load(input logic [7:0] w);
        src[0].push_back(w);
        src[1].push_back(w);
    endtask

    task automatic cycle(input bit r, input bit f, input bit rdy);
        bit         en  [2];
        bit         emp [2];
        logic [7:0] obs [2];
        bit         exp_en;
        bit         xf;
        logic [7:0] w;
        @(negedge clk);
        rst     = r;
        flush   = f;
        m_ready = rdy;
        for (int k = 0; k < 2; k++) begin
            emp[k]   = hold[k] || (src[k].size() == 0);
            empty[k] = emp[k];
        end
        rd_data[0] = (src[0].size() != 0) ? src[0][0] : 8'($urandom);
        rd_data[1] = nxt1;
        #1;
        for (int k = 0; k < 2; k++) begin
            exp_en = !r && !f && !emp[k] &&
                     (bufm[k].size() + pend[k].size() < k + 2);
            chk($sformatf("rd_en%0d", k), rd_en[k], exp_en);
            chk($sformatf("valid%0d", k), mv[k], bufm[k].size() != 0);
            chk($sformatf("cnt%0d", k), bc[k], bufm[k].size());
            if (bufm[k].size() != 0) begin
                chk($sformatf("data%0d", k), md[k], bufm[k][0]);
            end else if (zero_ok[k]) begin
                chk($sformatf("data_rst%0d", k), md[k], 0);
            end
            en[k]  = rd_en[k];
            obs[k] = md[k];
        end
        @(posedge clk);
        nxt1 = 8'($urandom);
        for (int k = 0; k < 2; k++) begin
            xf = !r && !f && rdy && (bufm[k].size() != 0);
            if (r || f) begin
                bufm[k].delete();
                pend[k].delete();
                if (r) zero_ok[k] = 1'b1;
            end else begin
                if (xf) begin
                    if (ph5 && k == 1 && obs[k] == 8'hAA) aa_seen++;
                    void'(bufm[k].pop_front());
                end
                if (pend[k].size() != 0) begin
                    bufm[k].push_back(pend[k].pop_front());
                    zero_ok[k] = 1'b0;
                end
            end
            if (en[k] && !emp[k]) begin
                w = src[k].pop_front();
                if (k == 1) begin
                    pend[1].push_back(w);
                    nxt1 = w;
                end else if (!(r || f)) begin
                    bufm[0].push_back(w);
                    zero_ok[0] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        aa_seen = 0;
        ph5     = 1'b0;
        nxt1    = 8'h00;
        rst     = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            hold[k]    = 1'b0;
            zero_ok[k] = 1'b0;
            empty[k]   = 1'b1;
            rd_data[k] = 8'h00;
        end

        // reset with a non-empty FIFO, then full-rate streaming
        for (int i = 1; i <= 8; i++) load(8'(i));
        repeat (3) cycle(1, 0, 1);
        repeat (12) cycle(0, 0, 1);

        // backpressure until credits run out, then release
        for (int i = 0; i < 8; i++) load(8'(8'h10 + i));
        repeat (5) cycle(0, 0, 0);
        repeat (12) cycle(0, 0, 1);

        // FIFO reports empty while the buffer drains
        for (int i = 0; i < 3; i++) load(8'(8'h30 + i));
        repeat (4) cycle(0, 0, 0);
        hold[0] = 1'b1;
        hold[1] = 1'b1;
        repeat (10) cycle(0, 0, 1);
        hold[0] = 1'b0;
        hold[1] = 1'b0;
        repeat (4) cycle(0, 0, 1);

        // flush while a word is in flight, with a handshake in the flush cycle
        repeat (2) cycle(1, 0, 0);
        load(8'h01);
        load(8'h02);
        load(8'hAA);
        load(8'hBB);
        ph5 = 1'b1;
        repeat (3) cycle(0, 0, 0);
        cycle(0, 1, 1);
        repeat (8) cycle(0, 0, 1);
        ph5 = 1'b0;
        chk("no_aa_after_flush", aa_seen, 0);

        // random mix of stalls, empties, flushes and resets
        for (int n = 0; n < 600; n++) begin
            while (src[0].size() < 4) load(8'($urandom));
            hold[0] = ($urandom_range(3) == 0);
            hold[1] = ($urandom_range(3) == 0);
            cycle($urandom_range(49) == 0,
                  $urandom_range(11) == 0,
                  $urandom_range(1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
